// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the MemUnit port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic       REQ_FETCH    = 1'b0;
    localparam logic       REQ_LS       = 1'b1;
    localparam logic [1:0] c_align_mask = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & c_align_mask) == 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_rr_pick
// Purpose  : Round-robin / ownership grant selection for two requesters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    input  arb_state_t state,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (state)
            ARB_IDLE: begin
                // On conflict the requester that did not win last time goes first
                if (req0 && req1) begin
                    gnt = (last_gnt == REQ_FETCH) ? 2'b10 : 2'b01;
                end else begin
                    gnt = {req1, req0};
                end
            end
            ARB_OWN0: gnt = {1'b0, req0};
            ARB_OWN1: gnt = {req1, 1'b0};
            default:  gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one MemUnit port between fetch and load/store requesters
//            with round-robin arbitration, locking and registered responses.
//            Optional grant/conflict statistics: define MEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              _clk,
    input  logic              _reset,
    input  logic              _req0,
    input  logic              _req1,
    input  logic              _we0,
    input  logic              _we1,
    input  logic [ADDR_W-1:0] _addr0,
    input  logic [ADDR_W-1:0] _addr1,
    input  logic [DATA_W-1:0] _wdata0,
    input  logic [DATA_W-1:0] _wdata1,
    input  logic              _lock0,
    input  logic              _lock1,
    output logic              gnt0_,
    output logic              gnt1_,
    output logic              rvalid0_,
    output logic              rvalid1_,
    output logic [DATA_W-1:0] rdata0_,
    output logic [DATA_W-1:0] rdata1_,
    output logic              err0_,
    output logic              err1_,
    output logic              mem_we_,
    output logic [ADDR_W-1:0] mem_vptr_,
    output logic [DATA_W-1:0] mem_sw_data_,
    input  logic [DATA_W-1:0] _mem_lw_data
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       grant_cnt0_,
    output logic [31:0]       grant_cnt1_,
    output logic [31:0]       conflict_cnt_
`endif
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last_gnt;
    logic              w_last_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;

    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic              w_any_gnt;
    logic              w_gnt_idx;
    logic              w_sel_we;
    logic              w_sel_lock;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_aligned;
    logic              w_load_ok;

    logic              w_owner;
    logic              w_owner_req;
    logic              w_owner_lock;
    logic              w_hold_done;

    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_err0;
    logic              r_err1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    mem_arb_rr_pick u_pick (
        .req0     (_req0),
        .req1     (_req1),
        .last_gnt (r_last_gnt),
        .state    (r_state),
        .gnt      (w_pick)
    );

    // Grants are forced low during reset so MemUnit contents survive init
    assign w_gnt     = _reset ? 2'b00 : w_pick;
    assign w_any_gnt = |w_gnt;
    assign w_gnt_idx = w_gnt[1];
    assign gnt0_     = w_gnt[0];
    assign gnt1_     = w_gnt[1];

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        if (w_gnt[0]) begin
            w_sel_we    = _we0;
            w_sel_lock  = _lock0;
            w_sel_addr  = _addr0;
            w_sel_wdata = _wdata0;
        end else if (w_gnt[1]) begin
            w_sel_we    = _we1;
            w_sel_lock  = _lock1;
            w_sel_addr  = _addr1;
            w_sel_wdata = _wdata1;
        end
    end

    assign w_aligned    = is_aligned(w_sel_addr[1:0]);
    assign w_load_ok    = !w_sel_we && w_aligned;
    assign mem_we_      = w_sel_we & w_aligned;
    assign mem_vptr_    = w_sel_addr;
    assign mem_sw_data_ = w_sel_wdata;

    assign w_owner      = (r_state == ARB_OWN1);
    assign w_owner_req  = w_owner ? _req1 : _req0;
    assign w_owner_lock = w_owner ? _lock1 : _lock0;
    assign w_hold_done  = (int'(r_hold_cnt) + 1) >= MAX_HOLD;

    always_ff @(posedge _clk or posedge _reset) begin
        if (_reset) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= REQ_LS;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_gnt <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_gnt;
        w_hold_nxt  = r_hold_cnt;
        if (w_any_gnt) begin
            w_last_nxt = w_gnt_idx;
        end
        case (r_state)
            ARB_IDLE: begin
                w_hold_nxt = '0;
                if (w_any_gnt && w_sel_lock) begin
                    w_state_nxt = w_gnt_idx ? ARB_OWN1 : ARB_OWN0;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                // Leaving ownership leaves last_gnt on the owner, so the
                // other requester takes the next conflict
                if (!w_owner_req || !w_owner_lock || w_hold_done) begin
                    w_state_nxt = ARB_IDLE;
                    w_hold_nxt  = '0;
                    w_last_nxt  = w_owner;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge _clk or posedge _reset) begin
        if (_reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt[0];
            r_rvalid1 <= w_gnt[1];
            r_err0    <= w_gnt[0] & !w_aligned;
            r_err1    <= w_gnt[1] & !w_aligned;
            if (w_gnt[0]) begin
                r_rdata0 <= w_load_ok ? _mem_lw_data : '0;
            end
            if (w_gnt[1]) begin
                r_rdata1 <= w_load_ok ? _mem_lw_data : '0;
            end
        end
    end

    assign rvalid0_ = r_rvalid0;
    assign rvalid1_ = r_rvalid1;
    assign err0_    = r_err0;
    assign err1_    = r_err1;
    assign rdata0_  = r_rdata0;
    assign rdata1_  = r_rdata1;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;
    logic [31:0] r_conflict_cnt;

    // At most one port is granted, so a cycle with both requesting always denies one
    always_ff @(posedge _clk or posedge _reset) begin
        if (_reset) begin
            r_grant_cnt0   <= '0;
            r_grant_cnt1   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_gnt[0] && (r_grant_cnt0 != '1)) begin
                r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            end
            if (w_gnt[1] && (r_grant_cnt1 != '1)) begin
                r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
            end
            if (_req0 && _req1 && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign grant_cnt0_   = r_grant_cnt0;
    assign grant_cnt1_   = r_grant_cnt1;
    assign conflict_cnt_ = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a MemUnit stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req   [2];
    logic          we    [2];
    logic          lock  [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_sw, lw;
    logic [AW-1:0] vptr;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]   gcnt0, gcnt1, ccnt;
`endif

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        ._clk         (clk),
        ._reset       (rst),
        ._req0        (req[0]),
        ._req1        (req[1]),
        ._we0         (we[0]),
        ._we1         (we[1]),
        ._addr0       (addr[0]),
        ._addr1       (addr[1]),
        ._wdata0      (wdata[0]),
        ._wdata1      (wdata[1]),
        ._lock0       (lock[0]),
        ._lock1       (lock[1]),
        .gnt0_        (gnt0),
        .gnt1_        (gnt1),
        .rvalid0_     (rvalid0),
        .rvalid1_     (rvalid1),
        .rdata0_      (rdata0),
        .rdata1_      (rdata1),
        .err0_        (err0),
        .err1_        (err1),
        .mem_we_      (mem_we),
        .mem_vptr_    (vptr),
        .mem_sw_data_ (mem_sw),
        ._mem_lw_data (lw)
`ifdef MEM_ARB_STATS_EN
        ,
        .grant_cnt0_   (gcnt0),
        .grant_cnt1_   (gcnt1),
        .conflict_cnt_ (ccnt)
`endif
    );

    function automatic logic [DW-1:0] pat(input int i);
        return 32'h1000_0000 + i * 32'h0001_0003;
    endfunction

    // MemUnit stub: combinational read, write on the clock edge
    assign lw = mem[vptr[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = pat(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[vptr[9:2]] <= mem_sw;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner (-1 = nobody), last winner, cycles held, responses
    int            m_owner, m_last, m_hold, g_exp;
    logic          m_rv   [2];
    logic          m_err  [2];
    logic [DW-1:0] m_rdata[2];
    int            n_g0, n_g1, n_conf;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_hold = 0;
        n_g0 = 0; n_g1 = 0; n_conf = 0;
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = 1'b0; m_err[p] = 1'b0; m_rdata[p] = '0;
        end
    endtask

    task automatic model_grant();
        g_exp = -1;
        if (!rst) begin
            if (m_owner >= 0) begin
                if (req[m_owner]) g_exp = m_owner;
            end else if (req[0] && req[1]) g_exp = 1 - m_last;
            else if (req[0]) g_exp = 0;
            else if (req[1]) g_exp = 1;
        end
    endtask

    task automatic model_step();
        int o;
        logic [AW-1:0] a;
        logic al;
        if (rst) begin
            model_reset();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            m_rv[p]  = (g_exp == p);
            m_err[p] = 1'b0;
            if (g_exp == p) begin
                a  = addr[p];
                al = (a[1:0] == 2'b00);
                m_err[p]   = !al;
                m_rdata[p] = (!we[p] && al) ? ref_mem[a[9:2]] : '0;
                if (we[p] && al) ref_mem[a[9:2]] = wdata[p];
            end
        end
        if (g_exp == 0) n_g0++;
        if (g_exp == 1) n_g1++;
        if (req[0] && req[1]) n_conf++;
        if (m_owner < 0) begin
            if (g_exp >= 0) begin
                m_last = g_exp;
                if (lock[g_exp]) begin m_owner = g_exp; m_hold = 0; end
            end
        end else begin
            o = m_owner;
            m_hold++;
            if (!req[o] || !lock[o] || m_hold >= MH) begin
                m_owner = -1; m_hold = 0; m_last = o;
            end
        end
    endtask

    task automatic sample();
        logic          e_we;
        logic [AW-1:0] e_ad;
        logic [DW-1:0] e_wd;
        @(negedge clk);
        model_grant();
        e_we = 1'b0; e_ad = '0; e_wd = '0;
        if (g_exp >= 0) begin
            e_ad = addr[g_exp];
            e_wd = wdata[g_exp];
            e_we = we[g_exp] && (e_ad[1:0] == 2'b00);
        end
        chk("gnt0", gnt0, g_exp == 0);
        chk("gnt1", gnt1, g_exp == 1);
        chk("mem_we", mem_we, e_we);
        chk("mem_vptr", vptr, e_ad);
        chk("mem_sw_data", mem_sw, e_wd);
        chk("rvalid0", rvalid0, m_rv[0]);
        chk("rvalid1", rvalid1, m_rv[1]);
        chk("err0", err0, m_err[0]);
        chk("err1", err1, m_err[1]);
        if (m_rv[0]) chk("rdata0", rdata0, m_rdata[0]);
        if (m_rv[1]) chk("rdata1", rdata1, m_rdata[1]);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic l);
        req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d; lock[p] = l;
    endtask

    typedef struct {
        logic          r0, w0, l0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1, l1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          g0, g1, mwe;   // this cycle
        logic          rv0, e0;       // response of the previous row
        logic [DW-1:0] rd0;
    } vec_t;

    function automatic vec_t mk(input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic g0, g1, mwe, rv0, e0, input logic [DW-1:0] rd0);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.rv0 = rv0; v.e0 = e0; v.rd0 = rd0;
        return v;
    endfunction

    vec_t vt[$];
    logic hold_sig [2];

    initial begin
        // Directed table (after reset: IDLE, requester 0 wins first conflict)
        vt.push_back(mk(1,0,0,32'h10,0,          1,0,0,32'h20,0,           1,0,0, 0,0,0));
        vt.push_back(mk(1,0,0,32'h10,0,          1,0,0,32'h20,0,           0,1,0, 1,0,pat(4)));
        vt.push_back(mk(1,0,0,32'h10,0,          1,0,0,32'h20,0,           1,0,0, 0,0,0));
        vt.push_back(mk(1,0,0,32'h10,0,          1,0,0,32'h20,0,           0,1,0, 1,0,pat(4)));
        vt.push_back(mk(0,0,0,0,0,               1,1,0,32'h40,32'hDEADBEEF, 0,1,1, 0,0,0));
        vt.push_back(mk(1,0,0,32'h40,0,          0,0,0,0,0,                1,0,0, 0,0,0));
        vt.push_back(mk(1,1,0,32'h42,32'h1234,   0,0,0,0,0,                1,0,0, 1,0,32'hDEADBEEF));
        vt.push_back(mk(0,0,0,0,0,               0,0,0,0,0,                0,0,0, 1,1,0));
        vt.push_back(mk(1,1,0,32'h80,32'hCAFE0001, 0,0,0,0,0,              1,0,1, 0,0,0));
        vt.push_back(mk(0,0,0,0,0,               1,0,0,32'h80,0,           0,1,0, 1,0,0));
        vt.push_back(mk(1,0,0,32'h10,0,          0,0,0,0,0,                1,0,0, 0,0,0));
        vt.push_back(mk(0,0,0,0,0,               0,0,0,0,0,                0,0,0, 1,0,pat(4)));

        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        for (int p = 0; p < 2; p++) set_port(p, 0, 0, '0, '0, 0);
        rst = 1'b1;
        model_reset();
        repeat (2) begin sample(); advance(); end
        chk("reset_rvalid0", rvalid0, 1'b0);
        chk("reset_rdata0", rdata0, '0);
        rst = 1'b0;

        foreach (vt[i]) begin
            set_port(0, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].l0);
            set_port(1, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1, vt[i].l1);
            sample();
            chk($sformatf("tbl%0d_gnt0", i), gnt0, vt[i].g0);
            chk($sformatf("tbl%0d_gnt1", i), gnt1, vt[i].g1);
            chk($sformatf("tbl%0d_mem_we", i), mem_we, vt[i].mwe);
            chk($sformatf("tbl%0d_rvalid0", i), rvalid0, vt[i].rv0);
            chk($sformatf("tbl%0d_err0", i), err0, vt[i].e0);
            if (vt[i].rv0) chk($sformatf("tbl%0d_rdata0", i), rdata0, vt[i].rd0);
            advance();
        end

        // Lock: three locked accesses by port 1, then an unlocked one
        set_port(0, 1, 0, 32'h20, 0, 0);
        set_port(1, 1, 0, 32'h30, 0, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) lock[1] = 1'b0;
            sample();
            chk("lock_gnt0_low", gnt0, 1'b0);
            chk("lock_gnt1", gnt1, 1'b1);
            advance();
        end
        sample();
        chk("lock_release_gnt0", gnt0, 1'b1);
        advance();

        // Forced release after MAX_HOLD cycles of ownership
        lock[1] = 1'b1;
        for (int k = 0; k < MH + 1; k++) begin
            sample();
            chk("hold_gnt1", gnt1, 1'b1);
            advance();
        end
        sample();
        chk("hold_forced_gnt0", gnt0, 1'b1);
        advance();

        // Reset during ownership of port 0 with a response pending
        set_port(1, 0, 0, '0, '0, 0);
        set_port(0, 1, 0, 32'h20, 0, 1);
        repeat (2) begin sample(); advance(); end
        chk("pend_rvalid0", rvalid0, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rdata0", rdata0, '0);
        chk("rst_err0", err0, 1'b0);
        chk("rst_gnt0", gnt0, 1'b0);
        repeat (2) begin sample(); advance(); end
        rst = 1'b0;
        set_port(0, 1, 0, 32'h10, 0, 0);
        set_port(1, 1, 0, 32'h20, 0, 0);
        sample();
        chk("post_rst_gnt0", gnt0, 1'b1);
        advance();

        // Randomized traffic; a denied requester holds its signals
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) hold_sig[p] = req[p] && (g_exp != p) && !rst;
            rst = ($urandom_range(0, 399) == 0);
            if (rst) model_reset();
            for (int p = 0; p < 2; p++) begin
                if (!hold_sig[p]) begin
                    logic [AW-1:0] a;
                    a = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
                    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                    set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a,
                             $urandom(), $urandom_range(0, 2) == 0);
                end
            end
            sample();
            advance();
        end
        rst = 1'b0;
        for (int p = 0; p < 2; p++) set_port(p, 0, 0, '0, '0, 0);
        sample();
        advance();
`ifdef MEM_ARB_STATS_EN
        chk("grant_cnt0", gcnt0, n_g0);
        chk("grant_cnt1", gcnt1, n_g1);
        chk("conflict_cnt", ccnt, n_conf);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single combinational-read / immediate-write port of one MemUnit instance between two requesters: port 0 (fetch) and port 1 (load/store).
- Round-robin arbitration with an optional per-requester lock, used for read-modify-write sequences.
- Registered read response one cycle after grant; misaligned-address error reporting.
- Sits between the core pipeline and MemUnit; drives MemUnit's _we/_vptr/_sw_data and consumes its lw_data_.

Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- DATA_W, 32, data width.
- MAX_HOLD, 8, max consecutive locked cycles before forced release (>=1).

Ports:
- _clk  in  1  clock, rising edge.
- _reset  in  1  reset, asynchronous, active-high.
- _req0 / _req1  in  1  access request, requester 0 / 1.
- _we0 / _we1  in  1  1=store, 0=load.
- _addr0 / _addr1  in  ADDR_W  byte address (word-aligned required).
- _wdata0 / _wdata1  in  DATA_W  store data.
- _lock0 / _lock1  in  1  keep ownership after this access.
- gnt0_ / gnt1_  out  1  combinational grant; the access happens this cycle.
- rvalid0_ / rvalid1_  out  1  registered response pulse, one cycle after grant.
- rdata0_ / rdata1_  out  DATA_W  registered load data; 0 for stores and errors.
- err0_ / err1_  out  1  with rvalid: access was misaligned.
- mem_we_  out  1  to MemUnit _we.
- mem_vptr_  out  ADDR_W  to MemUnit _vptr.
- mem_sw_data_  out  DATA_W  to MemUnit _sw_data.
- _mem_lw_data  in  DATA_W  from MemUnit lw_data_.

Behaviour:
- FSM states: ARB_IDLE, ARB_OWN0, ARB_OWN1. Reset state is ARB_IDLE.
- Reset values: last_gnt=1 (requester 0 wins first conflict), hold_cnt=0, rvalid*/err*=0, rdata*=0.
- While _reset is high: gnt*=0 and mem_we_=0, so MemUnit init is never overwritten.
- ARB_IDLE:
  - Only one request: grant it.
  - Both requesting: grant the requester != last_gnt.
  - On any grant, last_gnt <= granted index.
- ARB_OWNx: only requester x may be granted. The other's request waits (gnt low, no side effect).
- Transition to OWNx: on a granted access by x with _lockx=1.
- OWNx -> IDLE when any of:
  - x is granted with _lockx=0;
  - x has _reqx=0 for a cycle;
  - hold_cnt reaches MAX_HOLD.
- hold_cnt:
  - increments each cycle spent in OWNx; clears on leaving OWNx.
  - On forced release, last_gnt=x, so the other requester wins the next conflict.
- Memory drive (combinational from the granted port):
  - mem_vptr_=addr, mem_sw_data_=wdata, mem_we_=we & aligned.
  - With no grant, all three are 0.
- Aligned means addr[1:0]==2'b00. A misaligned access is still granted and consumes the slot, but mem_we_ stays 0.
- Response timing: on the posedge after grant, for the granted port:
  - rvalid=1 for exactly one cycle;
  - rdata=_mem_lw_data if load & aligned, else 0;
  - err=!aligned.
- Back-to-back grants to one port give back-to-back rvalid pulses. At most one port is granted per cycle.
- Request sampled with gnt=0 has no effect; requester holds its signals until granted.
- Reset asserted mid-lock or with a response pending: everything returns to reset values immediately; pending response is dropped.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - adds outputs grant_cnt0_, grant_cnt1_ (32-bit, count grants per port) and conflict_cnt_ (32-bit, counts cycles where both requested and one was denied, including lock-blocked cycles);
  - all counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state typedef (ARB_IDLE, ARB_OWN0, ARB_OWN1);
  - requester index constants REQ_FETCH=0, REQ_LS=1;
  - the alignment-mask constant.
- One combinational sub-module, mem_arb_rr_pick. Inputs: two requests, last_gnt, state. Outputs: one-hot grant.
- FSM, hold counter, response registers and stats stay in the top.

Test Plan:
- After reset, _req0=_req1=1, loads at 0x10/0x20 held:
  - grants alternate 0,1,0,1 on consecutive cycles;
  - each rvalid follows its grant by 1 cycle with the word at its address.
- Port 1 stores 0xDEADBEEF to 0x40, then port 0 loads 0x40:
  - mem_we_=1 only in the store-grant cycle;
  - load rdata0_=0xDEADBEEF.
- Port 1 with _lock1=1 for 3 accesses while _req0=1:
  - gnt0_ stays 0 through the locked accesses;
  - port 0 is granted the cycle after port 1's access with _lock1=0.
- MAX_HOLD=8, port 1 keeps _lock1=1 and _req1=1, port 0 requesting:
  - forced return to IDLE after 8 cycles in ARB_OWN1;
  - port 0 granted next.
- Port 0 store to 0x42:
  - gnt0_=1, mem_we_=0;
  - next cycle rvalid0_=1, err0_=1, rdata0_=0.
- _reset pulsed while in ARB_OWN0 with a response pending:
  - rvalid/err/rdata clear immediately, gnt*=0;
  - after release, requester 0 wins the first conflict.
